// File: rtl/cmd_frame_engine.sv
// cmd_frame_engine
//   Parses 8-byte control-centre frames [HDR0 HDR1 ID CMD ARG CHK TAIL0 TAIL1] from a
//   valid/ready byte stream. Valid frames drive host selection, per-channel reset pulses and
//   power enables for N_CH CPU channels. Rejected frames report a coded error.
//
//   Error codes: 1 bad second header byte, 2 tail mismatch, 3 checksum, 4 bad op/channel,
//                5 refused by channel policy, 6 inter-byte timeout.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_data      received byte
//   rx_valid     rx_data valid; a byte is taken when rx_valid & rx_ready
//   rx_ready     low only during the one-cycle execute state
//   host_sel     index of the current host channel
//   host_switch  1-clk pulse when host_sel changes
//   ch_reset     per-channel reset, high RST_CYCLES clocks
//   ch_power     per-channel power enable
//   frame_ok     1-clk pulse: frame accepted and executed
//   frame_err    1-clk pulse: frame rejected
//   err_code     code of the last rejection, held until the next frame_err
module cmd_frame_engine #(
   parameter int unsigned N_CH       = 2,
   parameter logic [7:0]  BOARD_ID   = 8'hAB,
   parameter logic [7:0]  HDR0       = 8'hEB,
   parameter logic [7:0]  HDR1       = 8'h90,
   parameter logic [7:0]  TAIL0      = 8'h09,
   parameter logic [7:0]  TAIL1      = 8'hD7,
   parameter int unsigned GAP_CYCLES = 1000,
   parameter int unsigned RST_CYCLES = 100,
   parameter logic [7:0]  FORCE_KEY  = 8'hA5,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            rx_ready,
   output logic [CH_W-1:0] host_sel,
   output logic            host_switch,
   output logic [N_CH-1:0] ch_reset,
   output logic [N_CH-1:0] ch_power,
   output logic            frame_ok,
   output logic            frame_err,
   output logic [2:0]      err_code
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   // Counter holds the number of pulse cycles still to come after the current one.
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
   localparam logic [3:0]       N_CH_4   = 4'(N_CH);

   localparam logic [2:0] ErrHdr   = 3'd1;
   localparam logic [2:0] ErrTail  = 3'd2;
   localparam logic [2:0] ErrSum   = 3'd3;
   localparam logic [2:0] ErrCmd   = 3'd4;
   localparam logic [2:0] ErrPol   = 3'd5;
   localparam logic [2:0] ErrGap   = 3'd6;

   typedef enum logic [1:0] {StHunt0, StHunt1, StBody, StExec} state_e;

   state_e           state_q;
   logic [2:0]       idx_q;
   logic [GAP_W-1:0] gap_q;
   logic [RST_W-1:0] rst_cnt_q [N_CH];
   logic [7:0]       id_q, cmd_q, arg_q, chk_q, tail0_q, tail1_q;

   logic             accept;
   logic [7:0]       sum;
   logic [3:0]       op, k;
   logic [CH_W-1:0]  k_idx;
   logic             k_is_host;
   logic             exec_ok, exec_err;
   logic [2:0]       exec_code;

   assign rx_ready  = (state_q != StExec);
   assign accept    = rx_valid & rx_ready;
   assign sum       = id_q + cmd_q + arg_q + chk_q;
   assign op        = cmd_q[7:4];
   assign k         = cmd_q[3:0];
   assign k_idx     = k[CH_W-1:0];
   assign k_is_host = (k == 4'(host_sel));

   // Frame check in priority order; an ID mismatch drops the frame with neither pulse.
   always_comb begin
      exec_ok   = 1'b0;
      exec_err  = 1'b0;
      exec_code = 3'd0;
      if (tail0_q != TAIL0 || tail1_q != TAIL1) begin
         exec_err  = 1'b1;
         exec_code = ErrTail;
      end else if (sum != 8'd0) begin
         exec_err  = 1'b1;
         exec_code = ErrSum;
      end else if (id_q != BOARD_ID) begin
         exec_ok   = 1'b0;
      end else if (k >= N_CH_4 || op > 4'd3) begin
         exec_err  = 1'b1;
         exec_code = ErrCmd;
      end else begin
         unique case (op[1:0])
            2'd0: begin
               exec_ok  = ch_power[k_idx];
               exec_err = !ch_power[k_idx];
            end
            2'd1: begin
               exec_err = k_is_host && (arg_q != FORCE_KEY);
               exec_ok  = !exec_err;
            end
            2'd2: exec_ok = 1'b1;
            2'd3: begin
               exec_err = k_is_host;
               exec_ok  = !k_is_host;
            end
            default: exec_ok = 1'b0;
         endcase
         if (exec_err) exec_code = ErrPol;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StHunt0;
         idx_q       <= 3'd0;
         gap_q       <= '0;
         host_sel    <= '0;
         host_switch <= 1'b0;
         ch_reset    <= '0;
         ch_power    <= '1;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= 3'd0;
         for (int i = 0; i < N_CH; i++) rst_cnt_q[i] <= '0;
      end else begin
         host_switch <= 1'b0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;

         for (int i = 0; i < N_CH; i++) begin
            if (ch_reset[i]) begin
               if (rst_cnt_q[i] == '0) ch_reset[i] <= 1'b0;
               else                    rst_cnt_q[i] <= rst_cnt_q[i] - 1'b1;
            end
         end

         case (state_q)
            StHunt0: begin
               gap_q <= '0;
               if (accept && rx_data == HDR0) state_q <= StHunt1;
            end

            StHunt1: begin
               if (accept) begin
                  gap_q <= '0;
                  if (rx_data == HDR1) begin
                     state_q <= StBody;
                     idx_q   <= 3'd2;
                  end else if (rx_data != HDR0) begin
                     // A repeated HDR0 keeps us here so a shifted header still syncs.
                     state_q   <= StHunt0;
                     frame_err <= 1'b1;
                     err_code  <= ErrHdr;
                  end
               end else if (gap_q == GAP_LAST) begin
                  gap_q     <= '0;
                  state_q   <= StHunt0;
                  frame_err <= 1'b1;
                  err_code  <= ErrGap;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            StBody: begin
               if (accept) begin
                  gap_q <= '0;
                  idx_q <= idx_q + 3'd1;
                  case (idx_q)
                     3'd2:    id_q    <= rx_data;
                     3'd3:    cmd_q   <= rx_data;
                     3'd4:    arg_q   <= rx_data;
                     3'd5:    chk_q   <= rx_data;
                     3'd6:    tail0_q <= rx_data;
                     default: tail1_q <= rx_data;
                  endcase
                  if (idx_q == 3'd7) state_q <= StExec;
               end else if (gap_q == GAP_LAST) begin
                  gap_q     <= '0;
                  state_q   <= StHunt0;
                  frame_err <= 1'b1;
                  err_code  <= ErrGap;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            StExec: begin
               state_q <= StHunt0;
               gap_q   <= '0;
               if (exec_err) begin
                  frame_err <= 1'b1;
                  err_code  <= exec_code;
               end else if (exec_ok) begin
                  frame_ok <= 1'b1;
                  unique case (op[1:0])
                     2'd0: begin
                        if (!k_is_host) begin
                           host_sel    <= k_idx;
                           host_switch <= 1'b1;
                        end
                     end
                     2'd1: begin
                        // Overrides the countdown above, so a re-trigger restarts the pulse.
                        ch_reset[k_idx]  <= 1'b1;
                        rst_cnt_q[k_idx] <= RST_LOAD;
                     end
                     2'd2: ch_power[k_idx] <= 1'b1;
                     2'd3: ch_power[k_idx] <= 1'b0;
                     default: ch_power[k_idx] <= ch_power[k_idx];
                  endcase
               end
            end

            default: state_q <= StHunt0;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_engine.sv
// Bench for cmd_frame_engine: a table of frames with expected outcomes, a pulse scoreboard,
// and hand-written sequences for resync, reset pulse length, timeout and mid-frame reset.
module tb_cmd_frame_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [0:0] host_sel;
   logic       host_switch;
   logic [1:0] ch_reset;
   logic [1:0] ch_power;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] err_code;

   cmd_frame_engine dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .host_sel   (host_sel),
      .host_switch(host_switch),
      .ch_reset   (ch_reset),
      .ch_power   (ch_power),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard of expected frame_ok/frame_err pulses.
   typedef struct {
      string      tag;
      bit         ok;
      logic [2:0] code;
      bit         sw;
   } exp_t;

   exp_t sbq[$];
   exp_t e_mon;

   function automatic void push_exp(input string tag, input bit ok, input logic [2:0] code,
                                    input bit sw);
      exp_t e;
      e.tag  = tag;
      e.ok   = ok;
      e.code = code;
      e.sw   = sw;
      sbq.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (!rst && host_switch && !frame_ok) check("switch_without_ok", 1, 0);
      if (!rst && (frame_ok || frame_err)) begin
         check("ok_err_exclusive", 32'(frame_ok & frame_err), 0);
         if (sbq.size() == 0) begin
            check("unexpected_pulse", {frame_ok, frame_err}, 0);
         end else begin
            e_mon = sbq.pop_front();
            check({e_mon.tag, "_ok"}, frame_ok, e_mon.ok);
            check({e_mon.tag, "_err"}, frame_err, !e_mon.ok);
            check({e_mon.tag, "_switch"}, host_switch, e_mon.sw);
            if (!e_mon.ok) check({e_mon.tag, "_code"}, err_code, e_mon.code);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int   waits = 0;
      logic acc   = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!acc && waits < 20) begin
         @(negedge clk);
         acc = rx_ready;
         @(posedge clk);
         waits++;
      end
      #1 rx_valid = 1'b0;
      if (!acc) check("rx_ready_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic [7:0] id, cmd, arg, chk, tail1);
      send_byte(8'hEB);
      send_byte(8'h90);
      send_byte(id);
      send_byte(cmd);
      send_byte(arg);
      send_byte(chk);
      send_byte(8'h09);
      send_byte(tail1);
   endtask

   function automatic logic [7:0] chk_of(input logic [7:0] id, cmd, arg);
      return 8'h00 - (id + cmd + arg);
   endfunction

   typedef struct {
      string      tag;
      logic [7:0] id, cmd, arg, delta, tail1;
      bit         pulse, ok;
      logic [2:0] code;
      bit         sw;
      logic       host;
      logic [1:0] power;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input string tag, input logic [7:0] id, cmd, arg, delta, tail1,
                                input bit pulse, ok, input logic [2:0] code, input bit sw,
                                input logic host, input logic [1:0] power);
      vec_t v;
      v.tag = tag; v.id = id; v.cmd = cmd; v.arg = arg; v.delta = delta; v.tail1 = tail1;
      v.pulse = pulse; v.ok = ok; v.code = code; v.sw = sw; v.host = host; v.power = power;
      vecs.push_back(v);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] last_code;
      logic [7:0] c;
      int         cnt;
      bit         other;

      //       tag          id     cmd    arg    dlt   tail1  pls ok code sw host power
      addv("sw_to1",      8'hAB, 8'h01, 8'hFF, 8'h0, 8'hD7, 1, 1, 3'd0, 1, 1'b1, 2'b11);
      addv("sw_same",     8'hAB, 8'h01, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 0, 1'b1, 2'b11);
      addv("sw_to0",      8'hAB, 8'h00, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 1, 1'b0, 2'b11);
      addv("rst_host",    8'hAB, 8'h10, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd5, 0, 1'b0, 2'b11);
      addv("bad_sum",     8'hAB, 8'h02, 8'h00, 8'h1, 8'hD7, 1, 0, 3'd3, 0, 1'b0, 2'b11);
      addv("bad_tail",    8'hAB, 8'h01, 8'h00, 8'h1, 8'hD6, 1, 0, 3'd2, 0, 1'b0, 2'b11);
      addv("bad_id",      8'hAC, 8'h31, 8'h00, 8'h0, 8'hD7, 0, 0, 3'd0, 0, 1'b0, 2'b11);
      addv("off1",        8'hAB, 8'h31, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 0, 1'b0, 2'b01);
      addv("sw_unpow",    8'hAB, 8'h01, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd5, 0, 1'b0, 2'b01);
      addv("k_range",     8'hAB, 8'h02, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd4, 0, 1'b0, 2'b01);
      addv("op_range",    8'hAB, 8'h40, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd4, 0, 1'b0, 2'b01);
      addv("off_host",    8'hAB, 8'h30, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd5, 0, 1'b0, 2'b01);
      addv("on1",         8'hAB, 8'h21, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 0, 1'b0, 2'b11);
      addv("sw_to1b",     8'hAB, 8'h01, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 1, 1'b1, 2'b11);
      addv("off0",        8'hAB, 8'h30, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 0, 1'b1, 2'b10);
      addv("rst_host1",   8'hAB, 8'h11, 8'h00, 8'h0, 8'hD7, 1, 0, 3'd5, 0, 1'b1, 2'b10);
      addv("on0",         8'hAB, 8'h20, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 0, 1'b1, 2'b11);
      addv("sw_to0b",     8'hAB, 8'h00, 8'h00, 8'h0, 8'hD7, 1, 1, 3'd0, 1, 1'b0, 2'b11);

      // Reset values.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_ready", rx_ready, 1);
      check("rst_host_sel", host_sel, 0);
      check("rst_ch_power", ch_power, 2'b11);
      check("rst_ch_reset", ch_reset, 0);
      check("rst_pulses", {host_switch, frame_ok, frame_err}, 0);
      check("rst_err_code", err_code, 0);
      rst = 1'b0;
      last_code = 3'd0;
      repeat (2) @(posedge clk);
      #1;

      // Table-driven frames.
      foreach (vecs[i]) begin
         c = chk_of(vecs[i].id, vecs[i].cmd, vecs[i].arg) + vecs[i].delta;
         if (vecs[i].pulse) push_exp(vecs[i].tag, vecs[i].ok, vecs[i].code, vecs[i].sw);
         if (vecs[i].pulse && !vecs[i].ok) last_code = vecs[i].code;
         send_frame(vecs[i].id, vecs[i].cmd, vecs[i].arg, c, vecs[i].tail1);
         repeat (3) @(posedge clk);
         #1;
         check({vecs[i].tag, "_host"}, host_sel, vecs[i].host);
         check({vecs[i].tag, "_power"}, ch_power, vecs[i].power);
         check({vecs[i].tag, "_code_held"}, err_code, last_code);
         check({vecs[i].tag, "_pulse_seen"}, sbq.size(), 0);
      end

      // Resync on a doubled HDR0, reset of the host without the key is refused.
      push_exp("resync_rst0", 0, 3'd5, 0);
      send_byte(8'hEB);
      send_frame(8'hAB, 8'h10, 8'h00, chk_of(8'hAB, 8'h10, 8'h00), 8'hD7);
      repeat (3) @(posedge clk);
      #1;
      check("resync_rst0_noreset", ch_reset, 0);

      // Forced reset of the host: pulse starts the cycle after EXEC, lasts 100 clocks.
      push_exp("force_rst0", 1, 3'd0, 0);
      send_frame(8'hAB, 8'h10, 8'hA5, chk_of(8'hAB, 8'h10, 8'hA5), 8'hD7);
      @(negedge clk);
      check("force_rst0_early", ch_reset, 0);
      @(negedge clk);
      cnt   = 0;
      other = 1'b0;
      while (ch_reset[0] && cnt < 300) begin
         cnt++;
         if (ch_reset[1]) other = 1'b1;
         @(negedge clk);
      end
      check("force_rst0_len", cnt, 100);
      check("force_rst0_ch1_quiet", 32'(other), 0);

      // Re-trigger while high restarts the count.
      push_exp("rst1_a", 1, 3'd0, 0);
      send_frame(8'hAB, 8'h11, 8'h00, chk_of(8'hAB, 8'h11, 8'h00), 8'hD7);
      repeat (20) @(posedge clk);
      push_exp("rst1_b", 1, 3'd0, 0);
      send_frame(8'hAB, 8'h11, 8'h00, chk_of(8'hAB, 8'h11, 8'h00), 8'hD7);
      @(negedge clk);
      check("retrig_still_high", ch_reset[1], 1);
      @(negedge clk);
      cnt = 0;
      while (ch_reset[1] && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      check("retrig_len", cnt, 100);

      // Bad second header byte; junk in HUNT0 gives no error.
      push_exp("hdr1_bad", 0, 3'd1, 0);
      send_byte(8'hEB);
      send_byte(8'h12);
      send_byte(8'h00);
      send_byte(8'h55);
      repeat (3) @(posedge clk);
      #1;
      check("hdr1_bad_code", err_code, 1);
      check("hdr1_bad_drained", sbq.size(), 0);

      // Timeout: error after exactly 1000 idle clocks, then a good frame is accepted.
      push_exp("timeout", 0, 3'd6, 0);
      send_byte(8'hEB);
      send_byte(8'h90);
      send_byte(8'hAB);
      repeat (999) @(posedge clk);
      @(negedge clk);
      check("timeout_not_early", frame_err, 0);
      @(posedge clk);
      @(negedge clk);
      check("timeout_at_1000", frame_err, 1);
      push_exp("after_timeout", 1, 3'd0, 1);
      send_frame(8'hAB, 8'h01, 8'h00, chk_of(8'hAB, 8'h01, 8'h00), 8'hD7);
      repeat (3) @(posedge clk);
      #1;
      check("after_timeout_host", host_sel, 1);

      // Reset mid-BODY while ch_reset[0] is pulsing and state differs from reset values.
      push_exp("pre_off0", 1, 3'd0, 0);
      send_frame(8'hAB, 8'h30, 8'h00, chk_of(8'hAB, 8'h30, 8'h00), 8'hD7);
      push_exp("pre_rst0", 1, 3'd0, 0);
      send_frame(8'hAB, 8'h10, 8'h00, chk_of(8'hAB, 8'h10, 8'h00), 8'hD7);
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_pulse", ch_reset, 2'b01);
      check("pre_rst_power", ch_power, 2'b10);
      send_byte(8'hEB);
      send_byte(8'h90);
      send_byte(8'hAB);
      send_byte(8'h21);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_host", host_sel, 0);
      check("midrst_power", ch_power, 2'b11);
      check("midrst_ch_reset", ch_reset, 0);
      check("midrst_err_code", err_code, 0);
      check("midrst_rx_ready", rx_ready, 1);
      check("midrst_pulses", {host_switch, frame_ok, frame_err}, 0);
      @(negedge clk);
      rst = 1'b0;
      push_exp("post_rst", 1, 3'd0, 1);
      send_frame(8'hAB, 8'h01, 8'h00, chk_of(8'hAB, 8'h01, 8'h00), 8'hD7);
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_host", host_sel, 1);
      check("post_rst_ch_reset", ch_reset, 0);

      repeat (5) @(posedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
